// File: rtl/dada_final_cpa.sv
// Final carry-propagate adder of the Dadda multiplier: sums the two residual
// rows CHUNK bits per clock, rippling the carry between chunks through a register.
module dada_final_cpa #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] row_a,
  input  logic [WIDTH-1:0] row_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   res_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk;

  // One chunk of the ripple: zero-extended so the top bit is the chunk carry-out.
  assign a_chunk    = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk    = b_q[idx_q*CHUNK +: CHUNK];
  assign chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  assign last_chunk = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = ADD;
      ADD:     if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operands are only sampled on accept, so the tree may move on immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= row_a;
            b_q     <= row_b;
            carry_q <= 1'b0;
            idx_q   <= '0;
          end
        end
        ADD: begin
          res_q[idx_q*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry_q                     <= chunk_sum[CHUNK];
          if (last_chunk) res_q[WIDTH] <= chunk_sum[CHUNK];
          else            idx_q        <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = res_q;

endmodule

// File: tb/tb_dada_final_cpa.sv
// Bench for dada_final_cpa: directed cases on the default build, then random
// traffic on CHUNK = 16, 64 and 8 builds against a plain-arithmetic model.
module tb_dada_final_cpa;

  logic clk;
  logic rst_n;
  logic [2:0]  in_valid, in_ready, out_valid, out_ready;
  logic [63:0] row_a [3];
  logic [63:0] row_b [3];
  logic [64:0] sum   [3];

  int checkCount = 0;
  int passCount  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane 0 is the default build, lane 1 a single-chunk build, lane 2 an 8-chunk build.
  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int CH = (g == 0) ? 16 : ((g == 1) ? 64 : 8);
    dada_final_cpa #(.WIDTH(64), .CHUNK(CH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .row_a     (row_a[g]),
      .row_b     (row_b[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .sum       (sum[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [64:0] observed,
                             input logic [64:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic applyStimulus(input int ln, input logic [63:0] a, input logic [63:0] b);
    int guard = 0;
    row_a[ln]    = a;
    row_b[ln]    = b;
    in_valid[ln] = 1'b1;
    while (!in_ready[ln] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) checkOutput($sformatf("L%0d_accept_timeout", ln), in_ready[ln], 1);
    @(negedge clk);
    in_valid[ln] = 1'b0;
    row_a[ln]    = {$urandom, $urandom};
    row_b[ln]    = {$urandom, $urandom};
  endtask

  // Counts clock edges from the accept edge until out_valid is seen.
  task automatic waitResult(input int ln, output int lat);
    lat = 0;
    while (!out_valid[ln] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid[ln]) checkOutput($sformatf("L%0d_result_timeout", ln), out_valid[ln], 1);
  endtask

  task automatic releaseOutput(input int ln);
    out_ready[ln] = 1'b1;
    @(negedge clk);
    out_ready[ln] = 1'b0;
    checkOutput($sformatf("L%0d_in_ready_after_xfer", ln), in_ready[ln], 1);
    checkOutput($sformatf("L%0d_out_valid_after_xfer", ln), out_valid[ln], 0);
  endtask

  task automatic runDirected(input string tag, input logic [63:0] a, input logic [63:0] b,
                             input logic [64:0] exp);
    int lat;
    applyStimulus(0, a, b);
    waitResult(0, lat);
    checkOutput({tag, "_sum"}, sum[0], exp);
    checkOutput({tag, "_latency"}, lat, 4);
    releaseOutput(0);
  endtask

  task automatic runTraffic(input int ln, input int nchunk);
    logic [63:0] a, b;
    logic [64:0] exp;
    int lat;
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      if (i % 10 == 0) b = ~a + 64'($urandom_range(0, 2));
      exp = {1'b0, a} + {1'b0, b};
      applyStimulus(ln, a, b);
      waitResult(ln, lat);
      checkOutput($sformatf("L%0d_rand%0d_sum", ln, i), sum[ln], exp);
      checkOutput($sformatf("L%0d_rand%0d_latency", ln, i), lat, nchunk);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checkOutput($sformatf("L%0d_rand%0d_hold", ln, i), sum[ln], exp);
      releaseOutput(ln);
    end
  endtask

  initial begin
    int lat;
    logic [63:0] pa, pb;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < 3; i++) begin
      row_a[i] = '0;
      row_b[i] = '0;
    end
    #1;
    checkOutput("rst_in_ready", in_ready[0], 1);
    checkOutput("rst_out_valid", out_valid[0], 0);
    checkOutput("rst_sum", sum[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    runDirected("basic", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111,
                65'h0_1234_5678_9ABC_DF00);
    runDirected("carry_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 65'h1_0000_0000_0000_0000);
    runDirected("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                65'h1_FFFF_FFFF_FFFF_FFFE);
    runDirected("chunk_boundary", 64'h0000_0000_0000_FFFF, 64'h1, 65'h1_0000);

    // Backpressure: a second pair waits upstream while the result is held.
    applyStimulus(0, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF);
    waitResult(0, lat);
    checkOutput("bp_first_latency", lat, 4);
    row_a[0]    = 64'h0000_0000_0000_0003;
    row_b[0]    = 64'h0000_0000_0000_0004;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("bp_hold_sum%0d", i), sum[0], 65'h0_DEAD_BEF0_0000_0000);
      checkOutput($sformatf("bp_hold_in_ready%0d", i), in_ready[0], 0);
      checkOutput($sformatf("bp_hold_out_valid%0d", i), out_valid[0], 1);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    checkOutput("bp_in_ready_after_xfer", in_ready[0], 1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    checkOutput("bp_pending_accepted", in_ready[0], 0);
    waitResult(0, lat);
    checkOutput("bp_second_sum", sum[0], 65'd7);
    checkOutput("bp_second_latency", lat, 4);
    releaseOutput(0);

    // Reset asserted between edges during the second ADD cycle.
    pa = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
    pb = {$urandom, $urandom} | 64'h0000_0000_0000_0001;
    applyStimulus(0, pa, pb);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", in_ready[0], 1);
    checkOutput("midrst_out_valid", out_valid[0], 0);
    checkOutput("midrst_sum", sum[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runDirected("after_rst", 64'd5, 64'd7, 65'd12);

    fork
      runTraffic(0, 4);
      runTraffic(1, 1);
      runTraffic(2, 8);
    join

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("%0d/%0d checks passed", passCount, checkCount + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
